// File: rtl/shreg8_pkg.sv
// Shared types and line-level constants for the shift-register receive link.
// Start/stop/idle levels are the framing contract with the far-end sender.
package shreg8_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STOP,
      RESYNC
   } rx_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shift register; one bit per shift_en cycle, no backpressure.
// MSB_FIRST selects which end the first received bit migrates to.
module sipo_shift #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             sdi,
   output logic [WIDTH-1:0] par_out
);

   generate
      if (MSB_FIRST) begin : g_msb
         always_ff @(posedge clk) begin
            if (reset)
               par_out <= '0;
            else if (shift_en)
               par_out <= {par_out[WIDTH-2:0], sdi};
         end
      end else begin : g_lsb
         always_ff @(posedge clk) begin
            if (reset)
               par_out <= '0;
            else if (shift_en)
               par_out <= {sdi, par_out[WIDTH-1:1]};
         end
      end
   endgenerate

endmodule

// File: rtl/shreg8_rx.sv
// Serial frame receiver (start + WIDTH data + stop) into a one-entry valid/ready buffer.
// q_valid rises the cycle after the stop-bit sample; a word arriving while the buffer is held is dropped and flagged as ovr.
module shreg8_rx
   import shreg8_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enbl,
   input  logic             sdi,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             frm_err,
   output logic             ovr,
   input  logic             clr_err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   rx_state_t        state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic             shift_en;
   logic             deliver;
   logic             frm_set;
   logic             ovr_set;
   logic             accept;
   logic [WIDTH-1:0] sr;

   sipo_shift #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_sipo (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .sdi      (sdi),
      .par_out  (sr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      shift_en = 1'b0;
      deliver  = 1'b0;
      frm_set  = 1'b0;
      if (enbl) begin
         case (state_q)
            IDLE: begin
               if (sdi == START_BIT) begin
                  state_d = DATA;
                  count_d = '0;
               end
            end
            DATA: begin
               shift_en = 1'b1;
               // Count saturates on the last data bit rather than wrapping.
               if (count_q == LAST_BIT)
                  state_d = STOP;
               else
                  count_d = count_q + 1'b1;
            end
            STOP: begin
               if (sdi == STOP_BIT) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  frm_set = 1'b1;
                  state_d = RESYNC;
               end
            end
            RESYNC: begin
               if (sdi == IDLE_LEVEL)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A simultaneous consume frees the slot for the incoming word.
   assign accept  = deliver && (!q_valid || q_ready);
   assign ovr_set = deliver && q_valid && !q_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (accept) begin
         q       <= sr;
         q_valid <= 1'b1;
      end else if (q_valid && q_ready) begin
         q_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frm_err <= 1'b0;
         ovr     <= 1'b0;
      end else begin
         if (frm_set)
            frm_err <= 1'b1;
         else if (clr_err)
            frm_err <= 1'b0;
         if (ovr_set)
            ovr <= 1'b1;
         else if (clr_err)
            ovr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shreg8_rx.sv
// Directed bench for shreg8_rx: both bit orders share one serial line; expected words queue at send time
// and are popped when the consumer handshakes.
module tb_shreg8_rx;

   logic       clk = 1'b0;
   logic       reset, enbl, sdi, q_ready, clr_err;
   logic [7:0] q_m, q_l;
   logic       qv_m, qv_l, fe_m, fe_l, ovr_m, ovr_l;

   int passes = 0;
   int checks = 0;

   logic [7:0] exp_m[$];
   logic [7:0] exp_l[$];

   always #5 clk = ~clk;

   shreg8_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .enbl(enbl), .sdi(sdi),
      .q(q_m), .q_valid(qv_m), .q_ready(q_ready),
      .frm_err(fe_m), .ovr(ovr_m), .clr_err(clr_err)
   );

   shreg8_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .enbl(enbl), .sdi(sdi),
      .q(q_l), .q_valid(qv_l), .q_ready(q_ready),
      .frm_err(fe_l), .ovr(ovr_l), .clr_err(clr_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   task automatic expect_word(input logic [7:0] d);
      exp_m.push_back(d);
      exp_l.push_back(rev8(d));
   endtask

   // Line toggles while enbl is low so a receiver that ignores enbl picks up garbage.
   task automatic send_bit(input logic b, input int gap);
      sdi  = b;
      enbl = 1'b1;
      tick();
      enbl = 1'b0;
      sdi  = ~b;
      repeat (gap) tick();
      sdi  = 1'b1;
   endtask

   task automatic send_data(input logic [7:0] d, input int gap);
      send_bit(1'b0, gap);
      for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
   endtask

   task automatic send_stop(input logic stop, input int gap, input logic rdy, input logic clr);
      q_ready = rdy;
      clr_err = clr;
      sdi     = stop;
      enbl    = 1'b1;
      tick();
      q_ready = 1'b0;
      clr_err = 1'b0;
      enbl    = 1'b0;
      sdi     = 1'b1;
      repeat (gap) tick();
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_data(d, 0);
      send_stop(1'b1, 0, 1'b0, 1'b0);
   endtask

   task automatic consume();
      if (exp_m.size() == 0 || exp_l.size() == 0) begin
         checks++;
         $error("FAIL sb_empty: observed no expected word queued, required one");
      end else begin
         chk("pop_valid_m", {31'b0, qv_m}, 32'd1);
         chk("pop_valid_l", {31'b0, qv_l}, 32'd1);
         chk("pop_q_m", {24'b0, q_m}, {24'b0, exp_m.pop_front()});
         chk("pop_q_l", {24'b0, q_l}, {24'b0, exp_l.pop_front()});
         q_ready = 1'b1;
         tick();
         q_ready = 1'b0;
         chk("post_pop_valid", {31'b0, qv_m}, 32'd0);
      end
   endtask

   task automatic clear_errs();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enbl = 1'b0; sdi = 1'b1; q_ready = 1'b0; clr_err = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_q", {24'b0, q_m}, 32'h0);
      chk("rst_valid", {31'b0, qv_m}, 32'd0);
      chk("rst_frm", {31'b0, fe_m}, 32'd0);
      chk("rst_ovr", {31'b0, ovr_m}, 32'd0);

      // 0xA5 with continuous strobe; valid appears right after the stop edge
      send_data(8'hA5, 0);
      chk("pre_stop_valid", {31'b0, qv_m}, 32'd0);
      expect_word(8'hA5);
      send_stop(1'b1, 0, 1'b0, 1'b0);
      chk("stop_latency", {31'b0, qv_m}, 32'd1);
      consume();

      // single leading one, strobe 1-in-4: 0x80 MSB-first, 0x01 LSB-first
      expect_word(8'h80);
      send_data(8'h80, 3);
      chk("gap_no_early_valid", {31'b0, qv_m}, 32'd0);
      send_stop(1'b1, 3, 1'b0, 1'b0);
      consume();

      // back-to-back frames, consumer stalled: second word dropped
      expect_word(8'h3C);
      send_frame(8'h3C);
      send_frame(8'hC3);
      chk("ovr_set", {31'b0, ovr_m}, 32'd1);
      chk("ovr_set_l", {31'b0, ovr_l}, 32'd1);
      consume();
      clear_errs();
      chk("ovr_clr", {31'b0, ovr_m}, 32'd0);

      // back-to-back with consume on the second delivery edge
      expect_word(8'h3C);
      send_frame(8'h3C);
      send_data(8'hC3, 0);
      chk("held_q", {24'b0, q_m}, {24'b0, exp_m.pop_front()});
      void'(exp_l.pop_front());
      expect_word(8'hC3);
      send_stop(1'b1, 0, 1'b1, 1'b0);
      chk("swap_valid", {31'b0, qv_m}, 32'd1);
      chk("swap_no_ovr", {31'b0, ovr_m}, 32'd0);
      consume();

      // bad stop, stuck-low line, recovery
      send_data(8'h55, 0);
      send_stop(1'b0, 0, 1'b0, 1'b0);
      chk("frm_set", {31'b0, fe_m}, 32'd1);
      chk("frm_no_deliver", {31'b0, qv_m}, 32'd0);
      repeat (5) send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      chk("resync_no_deliver", {31'b0, qv_m}, 32'd0);
      expect_word(8'h12);
      send_frame(8'h12);
      chk("frm_sticky", {31'b0, fe_m}, 32'd1);
      consume();
      clear_errs();
      chk("frm_clr", {31'b0, fe_m}, 32'd0);

      // reset mid-frame with a held word and ovr set
      send_frame(8'h99);
      send_frame(8'h77);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_m.delete();
      exp_l.delete();
      chk("mid_rst_q", {24'b0, q_m}, 32'h0);
      chk("mid_rst_valid", {31'b0, qv_m}, 32'd0);
      chk("mid_rst_ovr", {31'b0, ovr_m}, 32'd0);
      chk("mid_rst_frm", {31'b0, fe_m}, 32'd0);
      expect_word(8'hF0);
      send_frame(8'hF0);
      consume();

      // overrun set wins over a same-cycle clear
      expect_word(8'h5A);
      send_frame(8'h5A);
      send_data(8'h6B, 0);
      send_stop(1'b1, 0, 1'b0, 1'b1);
      chk("ovr_set_wins", {31'b0, ovr_m}, 32'd1);
      consume();
      clear_errs();
      chk("ovr_final_clr", {31'b0, ovr_m}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
